// File: rtl/usart_rx.sv
// 8N1 asynchronous serial receiver with a valid/ack holding register, overrun and frame-error flags.
// Define USART_RX_MAJORITY_EN to take each bit as a 3-of-centre majority vote instead of a single sample.
module usart_rx #(
   parameter int fsm_clk_freq    = 16000000,
   parameter int baud_rate       = 115200,
   parameter int fsm_clk_divider = fsm_clk_freq / baud_rate,
   parameter int half_divider    = fsm_clk_divider / 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] receivedbyte,
   output logic       received,
   input  logic       ack,
   output logic       frame_error,
   output logic       overrun,
   output logic       rx_led
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

   localparam logic [15:0] C_FULL = 16'(fsm_clk_divider - 1);
   localparam logic [15:0] C_HALF = 16'(half_divider - 1);

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_sync;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic [2:0]  r_bitidx, w_bitidx_nxt;
   logic [7:0]  r_shift, r_byte;
   logic        r_received, r_ferr, r_overrun;
   logic        w_rx_s, w_tick, w_sample, w_shift, w_good, w_ferr;

   assign w_rx_s = r_sync[1];
   assign w_tick = (r_cnt == 16'd0);

`ifdef USART_RX_MAJORITY_EN
   logic [1:0] r_hist;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // r_hist holds rx_s from the cycles where cnt was 2 and 1, so the vote lands on the tick.
   always_ff @(posedge clock) begin
      r_hist <= {r_hist[0], w_rx_s};
   end

   assign w_sample = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
   assign w_sample = w_rx_s;
`endif

   // Synchronizer, state, bit counter and index
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync   <= 2'b11;
         r_state  <= S_IDLE;
         r_cnt    <= 16'd0;
         r_bitidx <= 3'd0;
      end else begin
         r_sync   <= {r_sync[0], rx};
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_bitidx <= w_bitidx_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt - 16'd1;
      w_bitidx_nxt = r_bitidx;
      w_shift      = 1'b0;
      w_good       = 1'b0;
      w_ferr       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_rx_s) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = C_HALF;
            end
         end
         S_START: begin
            if (w_tick) begin
               if (!w_sample) begin
                  w_state_nxt  = S_DATA;
                  w_bitidx_nxt = 3'd0;
                  w_cnt_nxt    = C_FULL;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift      = 1'b1;
               w_cnt_nxt    = C_FULL;
               w_bitidx_nxt = r_bitidx + 3'd1;
               if (r_bitidx == 3'd7) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_tick) begin
               if (w_sample) begin
                  w_good      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            // A held-low (break) line must return high before a new start edge is armed.
            if (w_rx_s) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Byte assembly, LSB first
   always_ff @(posedge clock) begin
      if (w_shift) r_shift <= {w_sample, r_shift[7:1]};
   end

   // Host holding register and status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         r_byte     <= 8'h00;
         r_received <= 1'b0;
         r_ferr     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         if (ack && r_received) begin
            r_received <= 1'b0;
            r_overrun  <= 1'b0;
         end
         if (w_good) begin
            r_byte     <= r_shift;
            r_received <= 1'b1;
            if (r_received && !ack) r_overrun <= 1'b1;
         end
      end
   end

   assign receivedbyte = r_byte;
   assign received     = r_received;
   assign frame_error  = r_ferr;
   assign overrun      = r_overrun;
   assign rx_led       = (r_state != S_IDLE);

endmodule

// File: tb/tb_usart_rx.sv
// Scoreboard bench for usart_rx: expected bytes are queued as frames are driven and popped on each byte load.
module tb_usart_rx;

   localparam int BIT = 138;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic       ack   = 1'b0;
   logic [7:0] receivedbyte;
   logic       received, frame_error, overrun, rx_led;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int t_start = 0;
   int last_lat = 0;
   int ferr_cnt = 0;
   logic [7:0] exp_q[$];

   usart_rx dut (
      .clock(clock), .reset(reset), .rx(rx), .receivedbyte(receivedbyte),
      .received(received), .ack(ack), .frame_error(frame_error),
      .overrun(overrun), .rx_led(rx_led)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: a byte load is received rising, or the byte changing while received is held.
   logic       prev_rcv = 1'b0;
   logic [7:0] prev_byte = 8'h00;
   logic       prev_ferr = 1'b0;
   always @(negedge clock) begin
      logic [7:0] e;
      if (reset) begin
         prev_rcv = 1'b0; prev_byte = 8'h00; prev_ferr = 1'b0;
      end else begin
         if (received && (!prev_rcv || receivedbyte != prev_byte)) begin
            last_lat = cyc - t_start;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected_byte got %h expected none", receivedbyte);
            end else begin
               e = exp_q.pop_front();
               if (receivedbyte !== e) begin
                  n_fail++;
                  $display("FAIL sb_byte got %h expected %h", receivedbyte, e);
               end
            end
         end
         if (frame_error && !prev_ferr) ferr_cnt++;
         if (frame_error && prev_ferr) begin
            n_tests++; n_fail++;
            $display("FAIL ferr_width got 2+ cycles expected 1");
         end
         prev_rcv = received; prev_byte = receivedbyte; prev_ferr = frame_error;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Drives n_cyc clocks of an 8N1 frame; glitch inverts rx for one clock at each data-bit centre.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic glitch, input int n_cyc);
      logic v;
      int   b;
      t_start = cyc;
      for (int c = 0; c < n_cyc; c++) begin
         b = c / BIT;
         if (b == 0) v = 1'b0;
         else if (b <= 8) v = d[b-1];
         else v = stop_bit;
         if (glitch && b >= 1 && b <= 8 && (c % BIT) == BIT/2) v = ~v;
         rx = v;
         step(1);
      end
   endtask

   task automatic wait_rcv(input string name);
      int k = 0;
      while (!received && k < 200) begin step(1); k++; end
      chk({name, "_timeout"}, {7'd0, received}, 8'h01);
   endtask

   task automatic pulse_ack();
      ack = 1'b1; step(1); ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; rx = 1'b1; step(3);
      chk("rst_received", {7'd0, received}, 8'h00);
      chk("rst_byte", receivedbyte, 8'h00);
      chk("rst_ferr", {7'd0, frame_error}, 8'h00);
      chk("rst_overrun", {7'd0, overrun}, 8'h00);
      chk("rst_led", {7'd0, rx_led}, 8'h00);
      reset = 1'b0; step(5);
   endtask

   task automatic test_single();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0, 10*BIT);
      wait_rcv("single");
      chk("single_byte", receivedbyte, 8'hA5);
      n_tests++;
      if (last_lat < 1311 || last_lat > 1316) begin
         n_fail++;
         $display("FAIL single_latency got %0d expected 1311..1316", last_lat);
      end
      pulse_ack();
      chk("single_ack_clr", {7'd0, received}, 8'h00);
      chk("single_overrun", {7'd0, overrun}, 8'h00);
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      send_frame(8'h3C, 1'b1, 1'b0, 10*BIT);
      wait_rcv("b2b_first");
      pulse_ack();
      send_frame(8'hC3, 1'b1, 1'b0, 10*BIT);
      wait_rcv("b2b_second");
      chk("b2b_byte", receivedbyte, 8'hC3);
      chk("b2b_overrun", {7'd0, overrun}, 8'h00);
      pulse_ack();
      chk("b2b_ack_clr", {7'd0, received}, 8'h00);
   endtask

   task automatic test_overrun();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 1'b1, 1'b0, 10*BIT);
      send_frame(8'h22, 1'b1, 1'b0, 10*BIT);
      wait_rcv("ovr");
      chk("ovr_byte", receivedbyte, 8'h22);
      chk("ovr_flag", {7'd0, overrun}, 8'h01);
      pulse_ack();
      chk("ovr_ack_rcv", {7'd0, received}, 8'h00);
      chk("ovr_ack_flag", {7'd0, overrun}, 8'h00);
   endtask

   task automatic test_frame_error();
      int f0 = ferr_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 10*BIT);
      step(2000);
      chk("ferr_count", 8'(ferr_cnt - f0), 8'h01);
      chk("ferr_no_rcv", {7'd0, received}, 8'h00);
      chk("ferr_break_led", {7'd0, rx_led}, 8'h01);
      rx = 1'b1; step(20);
      chk("ferr_idle_led", {7'd0, rx_led}, 8'h00);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0, 10*BIT);
      wait_rcv("ferr_next");
      chk("ferr_next_byte", receivedbyte, 8'h81);
      chk("ferr_total", 8'(ferr_cnt - f0), 8'h01);
      pulse_ack();
   endtask

   task automatic test_glitch_and_reset();
      int f0 = ferr_cnt;
      rx = 1'b0; step(30);
      rx = 1'b1; step(300);
      chk("glitch_rcv", {7'd0, received}, 8'h00);
      chk("glitch_led", {7'd0, rx_led}, 8'h00);
      chk("glitch_ferr", 8'(ferr_cnt - f0), 8'h00);
      exp_q.push_back(8'h44);
      send_frame(8'h44, 1'b1, 1'b0, 10*BIT);
      wait_rcv("pre_rst");
      send_frame(8'h00, 1'b1, 1'b0, 5*BIT + BIT/2);
      chk("midframe_led", {7'd0, rx_led}, 8'h01);
      reset = 1'b1; rx = 1'b1; step(1);
      chk("midrst_received", {7'd0, received}, 8'h00);
      chk("midrst_byte", receivedbyte, 8'h00);
      chk("midrst_led", {7'd0, rx_led}, 8'h00);
      chk("midrst_overrun", {7'd0, overrun}, 8'h00);
      reset = 1'b0; step(20);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, 1'b0, 10*BIT);
      wait_rcv("post_rst");
      chk("post_rst_byte", receivedbyte, 8'h7E);
      pulse_ack();
   endtask

   task automatic test_majority();
      logic [7:0] e;
`ifdef USART_RX_MAJORITY_EN
      e = 8'h96;
`else
      e = 8'h69;
`endif
      exp_q.push_back(e);
      send_frame(8'h96, 1'b1, 1'b1, 10*BIT);
      wait_rcv("maj");
      chk("maj_byte", receivedbyte, e);
      pulse_ack();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_frame_error();
      test_glitch_and_reset();
      test_majority();
      step(10);
      chk("sb_drained", 8'(exp_q.size()), 8'h00);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
